// File: rtl/oserdes_frequency_synthesizer_pkg.sv
// Shared constants for the OSERDES frequency synthesizer: state encodings and default geometry.
package oserdes_frequency_synthesizer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int DEF_BIT_DEPTH           = 8;
  localparam int DEF_ACCUMULATOR_WIDTH   = 32;
  localparam int DEF_BURST_COUNTER_WIDTH = 16;

endpackage

// File: rtl/oserdes_frequency_synthesizer_phase_word_expander.sv
// Combinational: expands one word of serial bits (accumulator MSB per bit), cumulative rises and next acc.
// Bit i is serial bit i (transmitted i-th); rises include previous word's last bit -> bit 0.
module phase_word_expander
  import oserdes_frequency_synthesizer_pkg::*;
#(
  parameter int BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int ACC_W     = DEF_ACCUMULATOR_WIDTH,
  parameter int CW        = $clog2(DEF_BIT_DEPTH + 1)
) (
  input  logic [ACC_W-1:0]              i_acc,
  input  logic [ACC_W-1:0]              i_inc,
  input  logic                          i_prev_bit,
  output logic [BIT_DEPTH-1:0]          o_bits,
  output logic [BIT_DEPTH-1:0][CW-1:0]  o_cum_rises,
  output logic [ACC_W-1:0]              o_next_acc
);

  logic [ACC_W-1:0] w_phase;
  logic [CW-1:0]    w_rises;
  logic             w_prev;
  logic             w_bit;

  always_comb begin
    w_phase     = i_acc;
    w_rises     = '0;
    w_prev      = i_prev_bit;
    w_bit       = 1'b0;
    o_bits      = '0;
    o_cum_rises = '0;
    for (int i = 0; i < BIT_DEPTH; i++) begin
      w_phase        = w_phase + i_inc;
      w_bit          = w_phase[ACC_W-1];
      w_rises        = w_rises + CW'(w_bit & ~w_prev);
      o_bits[i]      = w_bit;
      o_cum_rises[i] = w_rises;
      w_prev         = w_bit;
    end
    o_next_acc = w_phase;
  end

endmodule

// File: rtl/oserdes_frequency_synthesizer.sv
// Phase-accumulator square-wave generator emitting BIT_DEPTH-bit OSERDES words (MSB sent first), continuous or N-pulse burst.
// One word per clock, first word one cycle after start; no backpressure. OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN adds edge_count.
module oserdes_frequency_synthesizer
  import oserdes_frequency_synthesizer_pkg::*;
#(
  parameter int BIT_DEPTH           = DEF_BIT_DEPTH,
  parameter int ACCUMULATOR_WIDTH   = DEF_ACCUMULATOR_WIDTH,
  parameter int BURST_COUNTER_WIDTH = DEF_BURST_COUNTER_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [ACCUMULATOR_WIDTH-1:0]   frequency_word,
  input  logic                           load,
  input  logic                           start,
  input  logic                           stop,
  input  logic [BURST_COUNTER_WIDTH-1:0] burst_length,
  output logic [BIT_DEPTH-1:0]           out,
  output logic                           busy,
  output logic                           done
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
  ,
  output logic [31:0]                    edge_count
`endif
);

  localparam int CW  = $clog2(BIT_DEPTH + 1);
  localparam int BCW = BURST_COUNTER_WIDTH;
  localparam int TW  = BCW + CW;
  localparam logic [TW-1:0] CNT_MAX = {{CW{1'b0}}, {BCW{1'b1}}};

  logic [0:0]                   r_state;
  logic [ACCUMULATOR_WIDTH-1:0] r_acc;
  logic [ACCUMULATOR_WIDTH-1:0] r_inc;
  logic                         r_prev_bit;
  logic [BCW-1:0]               r_rise_cnt;
  logic [BCW-1:0]               r_burst_len;
  logic [BIT_DEPTH-1:0]         r_out;
  logic                         r_busy;
  logic                         r_done;

  logic [BIT_DEPTH-1:0]          w_bits;
  logic [BIT_DEPTH-1:0][CW-1:0]  w_cum;
  logic [ACCUMULATOR_WIDTH-1:0]  w_next_acc;
  logic [BIT_DEPTH-1:0]          w_word;
  logic [TW-1:0]                 w_total;
  logic [TW-1:0]                 w_total_end;
  logic [BCW-1:0]                w_next_cnt;
  logic                          w_continuous;
  logic                          w_burst_done;

  phase_word_expander #(
    .BIT_DEPTH (BIT_DEPTH),
    .ACC_W     (ACCUMULATOR_WIDTH),
    .CW        (CW)
  ) u_expander (
    .i_acc       (r_acc),
    .i_inc       (r_inc),
    .i_prev_bit  (r_prev_bit),
    .o_bits      (w_bits),
    .o_cum_rises (w_cum),
    .o_next_acc  (w_next_acc)
  );

  // Raw rises are counted; bits from the (N+1)th rise onward are suppressed, so the emitted
  // stream holds exactly N complete pulses.
  always_comb begin
    w_continuous = (r_burst_len == '0);
    w_word       = '0;
    w_total      = '0;
    for (int i = 0; i < BIT_DEPTH; i++) begin
      w_total = TW'(r_rise_cnt) + TW'(w_cum[i]);
      w_word[BIT_DEPTH-1-i] = w_bits[i] & (w_continuous | (w_total <= TW'(r_burst_len)));
    end
    w_total_end  = TW'(r_rise_cnt) + TW'(w_cum[BIT_DEPTH-1]);
    w_next_cnt   = (w_total_end > CNT_MAX) ? {BCW{1'b1}} : w_total_end[BCW-1:0];
    w_burst_done = ~w_continuous & (w_total_end >= TW'(r_burst_len)) & ~w_word[0];
  end

`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
  logic [31:0]   r_edge_count;
  logic [TW-1:0] w_emitted;
  logic [32:0]   w_edge_sum;

  // While bursting, r_rise_cnt never exceeds N, so the difference cannot underflow.
  always_comb begin
    if (w_continuous)
      w_emitted = TW'(w_cum[BIT_DEPTH-1]);
    else if (w_total_end > TW'(r_burst_len))
      w_emitted = TW'(r_burst_len) - TW'(r_rise_cnt);
    else
      w_emitted = w_total_end - TW'(r_rise_cnt);
    w_edge_sum = {1'b0, r_edge_count} + 33'(w_emitted);
  end

  assign edge_count = r_edge_count;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_inc       <= '0;
      r_prev_bit  <= 1'b0;
      r_rise_cnt  <= '0;
      r_burst_len <= '0;
      r_out       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
      r_edge_count <= '0;
`endif
    end else begin
      // Busy still high while already idle means the last word was a completed burst.
      r_done <= (r_state == ST_IDLE) & r_busy;
      if (r_state == ST_IDLE) begin
        r_out  <= '0;
        r_busy <= 1'b0;
        if (start && !stop) begin
          r_state     <= ST_RUN;
          r_acc       <= '0;
          r_inc       <= frequency_word;
          r_prev_bit  <= 1'b0;
          r_rise_cnt  <= '0;
          r_burst_len <= burst_length;
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
          r_edge_count <= '0;
`endif
        end
      end else if (stop) begin
        r_state <= ST_IDLE;
        r_out   <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_out      <= w_word;
        r_busy     <= 1'b1;
        r_acc      <= w_next_acc;
        r_prev_bit <= w_bits[BIT_DEPTH-1];
        r_rise_cnt <= w_next_cnt;
        if (load)
          r_inc <= frequency_word;
        if (w_burst_done)
          r_state <= ST_IDLE;
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
        r_edge_count <= w_edge_sum[32] ? 32'hFFFF_FFFF : w_edge_sum[31:0];
`endif
      end
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_oserdes_frequency_synthesizer.sv
// Bench for oserdes_frequency_synthesizer: serial-bit reference model, directed scenarios and random traffic.
module tb_oserdes_frequency_synthesizer;

  logic        clock;
  logic        reset_n;
  logic [31:0] frequency_word;
  logic        load;
  logic        start;
  logic        stop;
  logic [15:0] burst_length;
  logic [7:0]  out;
  logic        busy;
  logic        done;
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
  logic [31:0] edge_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  oserdes_frequency_synthesizer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .frequency_word (frequency_word),
    .load           (load),
    .start          (start),
    .stop           (stop),
    .burst_length   (burst_length),
    .out            (out),
    .busy           (busy),
    .done           (done)
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
    ,
    .edge_count     (edge_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: generates the serial stream bit by bit.
  bit          m_run;
  bit [31:0]   m_phase;
  bit [31:0]   m_inc;
  bit          m_raw_prev;
  int unsigned m_raw_rises;
  int unsigned m_n;
  bit          m_emit_prev;
  longint      m_emit_rises;
  bit          m_done_pending;
  logic [7:0]  e_out;
  logic        e_busy;
  logic        e_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_phase = 0; m_inc = 0; m_raw_prev = 0; m_raw_rises = 0; m_n = 0;
    m_emit_prev = 0; m_emit_rises = 0; m_done_pending = 0;
    e_out = 0; e_busy = 0; e_done = 0;
  endfunction

  function automatic void model_step();
    logic [7:0] word;
    bit b, eb;
    e_done = m_done_pending;
    m_done_pending = 0;
    if (!m_run) begin
      e_out = 0; e_busy = 0;
      if (start && !stop) begin
        m_run = 1; m_phase = 0; m_inc = frequency_word; m_raw_prev = 0; m_raw_rises = 0;
        m_n = burst_length; m_emit_prev = 0; m_emit_rises = 0;
      end
    end else if (stop) begin
      m_run = 0; e_out = 0; e_busy = 0;
    end else begin
      word = 0;
      for (int i = 0; i < 8; i++) begin
        m_phase = m_phase + m_inc;
        b = m_phase[31];
        if (b && !m_raw_prev) m_raw_rises++;
        m_raw_prev = b;
        eb = b && (m_n == 0 || m_raw_rises <= m_n);
        word[7-i] = eb;
        if (eb && !m_emit_prev) m_emit_rises++;
        m_emit_prev = eb;
      end
      e_out = word; e_busy = 1;
      if (load) m_inc = frequency_word;
      if (m_n != 0 && m_emit_rises == longint'(m_n) && !m_emit_prev) begin
        m_run = 0; m_done_pending = 1;
      end
    end
  endfunction

  task automatic compare();
    chk("out", {56'd0, out}, {56'd0, e_out});
    chk("busy", {63'd0, busy}, {63'd0, e_busy});
    chk("done", {63'd0, done}, {63'd0, e_done});
    chk("acc", {32'd0, dut.r_acc}, {32'd0, m_phase});
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
    chk("edge_count", {32'd0, edge_count},
        (m_emit_rises > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_emit_rises);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic do_start(input logic [31:0] inc, input logic [15:0] n);
    frequency_word = inc; burst_length = n; start = 1;
    step();
    start = 0;
  endtask

  function automatic logic [31:0] pick_inc();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(32'h0100_0000, 32'h2000_0000);
      2:       return 32'h1 << $urandom_range(26, 31);
      default: return ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom_range(32'h0800_0000, 32'h7000_0000);
    endcase
  endfunction

  initial begin
    reset_n = 0; frequency_word = 0; load = 0; start = 0; stop = 0; burst_length = 0;
    model_reset();
    #12;
    compare();
    @(negedge clock);
    reset_n = 1;

    // continuous 2^29: one pulse per word
    do_start(32'h2000_0000, 16'd0);
    chk("t1_busy_after_start_edge", {63'd0, busy}, 64'd0);
    repeat (3) step();
    chk("t1_out_lit", {56'd0, out}, 64'h1E);
    chk("t1_model_lit", {56'd0, e_out}, 64'h1E);
    stop = 1; step(); stop = 0;

    // continuous 2^30: two pulses per word
    do_start(32'h4000_0000, 16'd0);
    repeat (3) step();
    chk("t2_out_lit", {56'd0, out}, 64'h66);
    chk("t2_model_lit", {56'd0, e_out}, 64'h66);
    stop = 1; step(); stop = 0;
    step();

    // burst of 3 at 2^30
    do_start(32'h4000_0000, 16'd3);
    step();
    chk("t3_word1", {56'd0, out}, 64'h66);
    step();
    chk("t3_word2", {56'd0, out}, 64'h60);
    chk("t3_word2_busy", {63'd0, busy}, 64'd1);
    step();
    chk("t3_zero_word", {56'd0, out}, 64'h00);
    chk("t3_done", {63'd0, done}, 64'd1);
    chk("t3_busy_fall", {63'd0, busy}, 64'd0);
    step();
    chk("t3_done_one_cycle", {63'd0, done}, 64'd0);

    // load switches increment at the following word
    do_start(32'h2000_0000, 16'd0);
    step(); step();
    frequency_word = 32'h4000_0000; load = 1;
    step();
    load = 0;
    chk("t4_load_edge_word", {56'd0, out}, 64'h1E);
    step();
    chk("t4_new_inc_word", {56'd0, out}, 64'h66);
    stop = 1; step(); stop = 0;

    // stop while the output is high
    do_start(32'h1000_0000, 16'd0);
    step();
    chk("t5_word1", {56'd0, out}, 64'h01);
    step();
    chk("t5_word2", {56'd0, out}, 64'hFE);
    stop = 1; step(); stop = 0;
    chk("t5_stop_out", {56'd0, out}, 64'h00);
    chk("t5_stop_busy", {63'd0, busy}, 64'd0);
    step(); step();
    chk("t5_no_done", {63'd0, done}, 64'd0);
    frequency_word = 32'h2000_0000; start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    step();
    chk("t5_start_stop_idle", {63'd0, busy}, 64'd0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int r;
      start = 0; stop = 0; load = 0;
      r = $urandom_range(0, 99);
      if (!m_run) begin
        if (r < 40) begin
          start = 1; frequency_word = pick_inc(); burst_length = 16'($urandom_range(0, 6));
          stop = (r < 3);
        end else if (r < 46) begin
          load = 1; frequency_word = pick_inc();
        end
      end else begin
        if (r < 8) begin load = 1; frequency_word = pick_inc(); end
        else if (r < 11) stop = 1;
        else if (r < 14) begin start = 1; frequency_word = pick_inc(); end
      end
      step();
    end
    start = 0; stop = 0; load = 0;
    stop = 1; step(); stop = 0;
    step();

    // long run then asynchronous reset mid-RUN
    do_start(32'h2000_0000, 16'd0);
    repeat (100) step();
`ifdef OSERDES_FREQUENCY_SYNTHESIZER_EDGE_COUNT_EN
    chk("t6_edge_count_lit", {32'd0, edge_count}, 64'd100);
`endif
    chk("t6_running_busy", {63'd0, busy}, 64'd1);
    @(posedge clock);
    #2 reset_n = 0;
    #1;
    chk("t6_async_out", {56'd0, out}, 64'h00);
    chk("t6_async_busy", {63'd0, busy}, 64'd0);
    model_reset();
    @(negedge clock);
    compare();
    reset_n = 1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
